hyperbus_target: RTL
====================

Name: hyperbus_target

Overview:
Synthesizable HyperRAM-style responder: the device end of the 8-bit HyperBus link that the hyperbus controller drives. It oversamples the bus in the system clock domain, decodes the 48-bit command/address, holds off for a fixed latency, then accepts write bursts or returns read bursts from an internal word array. It also implements a minimal register space. It is used as the on-chip bus partner for controller/FIFO benches and FPGA loopback.

Parameters:
DEPTH_LOG2, 10, internal memory size in 16-bit words (2**DEPTH_LOG2)
LATENCY, 6, initial latency in hbus_clk cycles; fixed 2x latency always applied to memory space
ID0_VAL, 16'h0C81, value returned for register read at word address 0x000000
CR0_RST, 16'h8F1F, CR0 reset value at word address 0x000800

Ports:
clk  input  1  system clock, must be >= 4x hbus_clk frequency
rstn  input  1  synchronous active-low reset
hbus_clk  input  1  bus clock from the controller, asynchronous to clk
hbus_csn  input  1  chip select, active low
hbus_rstn  input  1  bus reset; low has the same effect as rstn, except the memory array is left intact
hbus_dq_i  input  8  DQ from controller
hbus_dq_o  output  8  DQ to controller
hbus_dq_oe  output  1  DQ output enable
hbus_rwds_i  input  1  write mask from controller during the data phase (1 = byte masked)
hbus_rwds_o  output  1  RWDS driven by target
hbus_rwds_oe  output  1  RWDS output enable
busy  output  1  high whenever the state is not IDLE
error_o  output  1  one-clk pulse on the csn rise that aborts an odd-byte write word

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE; dq_o=0, dq_oe=0, rwds_o=0, rwds_oe=0, busy=0, error_o=0
  - CR0=CR0_RST; memory array contents undefined
- Sync sub-module:
  - 2-flop synchronizes hbus_clk, csn and rwds_i; dq_i is delayed by the same two stages so data aligns with edge detection.
  - Emits edge_p for any hbus_clk transition (rise or fall); each edge carries one byte.
- Byte order: the first byte of every word is [15:8].
- CA decode, 6 bytes, MSB first:
  - CA[47]=read
  - CA[46]=register space
  - CA[45]=linear burst (wrapped bursts are treated as linear)
  - word address = {CA[44:16], CA[2:0]}, truncated to DEPTH_LOG2 bits
- IDLE: a synchronized csn fall enters CA with byte count 0.
  - rwds_oe=1 and rwds_o=1 for the whole CA and latency phases: fixed 2x latency is always signalled.
- CA: capture a byte on each edge_p. On the 6th byte:
  - register write -> WRITE immediately (zero latency)
  - otherwise -> LAT, with the counter loaded to 4*LATENCY edges
- LAT: decrement the counter per edge_p. At 0:
  - read -> READ
  - write -> WRITE, and rwds_oe drops to 0
- WRITE: bytes alternate high/low.
  - Each byte is stored only if its synchronized rwds_i=0; masking is per byte.
  - The address increments after the low byte.
  - Register write: only address 0x000800 (CR0) is writable and is not maskable; all others are ignored.
- READ: on each edge_p, drive the next byte on dq_o, with dq_oe=1 and rwds_o toggling (0 with the high byte, 1 with the low byte), at one clk after edge detection.
  - The address increments after the low byte.
  - Register reads: 0x000000 returns ID0_VAL, 0x000800 returns CR0, everything else returns 0.
- Address wrap: address top -> 0 silently; bursts are unbounded.
- Synchronized csn rise in any state:
  - next clk: state=IDLE and all oe=0
  - a pending half-written word (high byte only) is discarded, and error_o pulses for 1 clk
- hbus_rstn low, or rstn low mid-burst: immediate IDLE per above; rstn has priority.
- If csn rises and falls within the same synchronizer window, the csn rise takes priority; the new transaction is recognised on the next observed fall.

Decomposition:
- hyperbus_pkg holds:
  - CA bit-position constants (CA_RW=47, CA_AS=46, CA_BT=45)
  - CR0/ID0 word-address constants
  - state enum {IDLE, CA, LAT, WRITE, READ}
- One sub-module, hyperbus_target_sync: synchronizer plus edge detector producing edge_p, csn_s, csn_rise, csn_fall, dq_s, rwds_s.
- The memory array is inferred inline.

Test Plan:
- Write burst, memory space, address 0x10: data 0xDEAD, 0xBEEF, rwds_i=0 -> words[0x10]=0xDEAD, words[0x11]=0xBEEF; rwds held high through CA plus 24 latency edges.
- Read back the same address with 2 words -> dq bytes DE,AD,BE,EF, rwds_o toggling 0,1,0,1; dq_oe deasserts 1 clk after csn rise.
- Masked write 0x1234 to 0x10 with rwds_i=1 on the low byte -> read returns 0x12AD.
- Register read at 0x000000 -> 0x0C81. Register write 0x8F17 to CR0 with no latency, then read CR0 -> 0x8F17.
- Write burst starting at address 0x3FF, 2 words -> second word lands at 0x000. Then csn rise after 1 byte of the third word -> error_o single pulse, and no array change.
- Assert rstn=0 for 1 clk mid-read -> all outputs 0 the next clk, busy=0, CR0=0x8F1F.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus target.
// Holds the command/address bit positions, the register-space word
// addresses, the responder state encoding and a small helper that
// extracts the word address from a completed 48-bit CA.
package hyperbus_pkg;

  // Bit positions inside the 48-bit command/address word
  localparam int CA_RW = 47;
  localparam int CA_AS = 46;
  localparam int CA_BT = 45;

  // Register-space word addresses
  localparam logic [31:0] ID0_ADDR = 32'h0000_0000;
  localparam logic [31:0] CR0_ADDR = 32'h0000_0800;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CA    = 3'd1,
    LAT   = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_e;

  // Word address = {CA[44:16], CA[2:0]}; CA[15:3] are reserved
  function automatic logic [31:0] caWordAddr(input logic [47:0] ca);
    return {ca[44:16], ca[2:0]};
  endfunction

endpackage

// File: rtl/hyperbus_target_sync.sv
// Brings the asynchronous HyperBus pins into the clk domain.
// hbus_clk, csn and rwds pass through two flops; dq is delayed by the
// same two stages so each byte lines up with the detected clock edge.
// Ports:
//   clk, rstn        system clock and synchronous active-low reset
//   hbus_clk_i       bus clock from the controller
//   hbus_csn_i       chip select, active low
//   hbus_rwds_i      RWDS / write mask from the controller
//   hbus_dq_i        DQ from the controller
//   edge_p_o         one-clk pulse on any hbus_clk transition
//   csn_s_o          synchronized chip select
//   csn_rise_o       one-clk pulse when synchronized csn goes high
//   csn_fall_o       one-clk pulse when synchronized csn goes low
//   dq_s_o           DQ aligned with edge_p_o
//   rwds_s_o         RWDS aligned with edge_p_o
module hyperbus_target_sync (
  input  logic       clk,
  input  logic       rstn,
  input  logic       hbus_clk_i,
  input  logic       hbus_csn_i,
  input  logic       hbus_rwds_i,
  input  logic [7:0] hbus_dq_i,
  output logic       edge_p_o,
  output logic       csn_s_o,
  output logic       csn_rise_o,
  output logic       csn_fall_o,
  output logic [7:0] dq_s_o,
  output logic       rwds_s_o
);

  // Bit 0 is the first synchronizer stage, bit 1 the usable value,
  // bit 2 the previous usable value for edge detection.
  logic [2:0] clk_q;
  logic [2:0] csn_q;
  logic [1:0] rwds_q;
  logic [7:0] dq1_q;
  logic [7:0] dq2_q;

  // Shift register for the synchronizers; csn resets to deselected so a
  // reset never looks like a new transaction start.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_q  <= 3'b000;
      csn_q  <= 3'b111;
      rwds_q <= 2'b00;
      dq1_q  <= 8'h00;
      dq2_q  <= 8'h00;
    end else begin
      clk_q  <= {clk_q[1:0], hbus_clk_i};
      csn_q  <= {csn_q[1:0], hbus_csn_i};
      rwds_q <= {rwds_q[0], hbus_rwds_i};
      dq1_q  <= hbus_dq_i;
      dq2_q  <= dq1_q;
    end
  end

  assign edge_p_o   = clk_q[1] ^ clk_q[2];
  assign csn_s_o    = csn_q[1];
  assign csn_rise_o = csn_q[1] & ~csn_q[2];
  assign csn_fall_o = ~csn_q[1] & csn_q[2];
  assign dq_s_o     = dq2_q;
  assign rwds_s_o   = rwds_q[1];

endmodule

// File: rtl/hyperbus_target.sv
// HyperRAM-style responder for the 8-bit HyperBus link.
// Oversamples the bus in the clk domain, decodes the 48-bit CA, waits a
// fixed 2x latency (memory space and register reads), then accepts write
// bursts into or returns read bursts from an internal 16-bit word array.
// A minimal register space provides ID0 (read-only) and CR0.
// Ports:
//   clk, rstn                 system clock (>= 4x hbus_clk), sync active-low reset
//   hbus_clk, hbus_csn        bus clock and chip select from the controller
//   hbus_rstn                 bus reset; same as rstn but leaves the array intact
//   hbus_dq_i/_o, hbus_dq_oe  data bus in/out and output enable
//   hbus_rwds_i/_o/_oe        RWDS in (write mask), out, output enable
//   busy                      state is not IDLE
//   error_o                   pulse when csn rise aborts a half-written word
module hyperbus_target
  import hyperbus_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 6,
  parameter logic [15:0] ID0_VAL    = 16'h0C81,
  parameter logic [15:0] CR0_RST    = 16'h8F1F
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       hbus_clk,
  input  logic       hbus_csn,
  input  logic       hbus_rstn,
  input  logic [7:0] hbus_dq_i,
  output logic [7:0] hbus_dq_o,
  output logic       hbus_dq_oe,
  input  logic       hbus_rwds_i,
  output logic       hbus_rwds_o,
  output logic       hbus_rwds_oe,
  output logic       busy,
  output logic       error_o
);

  // Latency is counted in DDR edges: two edges per hbus_clk cycle, doubled
  // because the fixed 2x latency is always applied.
  localparam logic [7:0] LAT_EDGES = 8'(4 * LATENCY);

  logic       edge_p;
  logic       csn_s;
  logic       csn_rise;
  logic       csn_fall;
  logic [7:0] dq_s;
  logic       rwds_s;

  hyperbus_target_sync u_sync (
    .clk         (clk),
    .rstn        (rstn),
    .hbus_clk_i  (hbus_clk),
    .hbus_csn_i  (hbus_csn),
    .hbus_rwds_i (hbus_rwds_i),
    .hbus_dq_i   (hbus_dq_i),
    .edge_p_o    (edge_p),
    .csn_s_o     (csn_s),
    .csn_rise_o  (csn_rise),
    .csn_fall_o  (csn_fall),
    .dq_s_o      (dq_s),
    .rwds_s_o    (rwds_s)
  );

  state_e      state_q;
  logic [2:0]  caCnt_q;
  logic [7:0]  latCnt_q;
  logic [39:0] ca_q;
  logic [31:0] addr_q;
  logic        isRead_q;
  logic        isReg_q;
  logic        hiPhase_q;
  logic        pending_q;
  logic [7:0]  hiByte_q;
  logic        hiMask_q;
  logic [15:0] cr0_q;
  logic [7:0]  dqOut_q;
  logic        dqOe_q;
  logic        rwdsOut_q;
  logic        rwdsOe_q;
  logic        error_q;

  logic [15:0] mem [2**DEPTH_LOG2];

  logic [47:0]           caNext;
  logic                  byteEdge;
  logic [DEPTH_LOG2-1:0] memAddr;
  logic [15:0]           rdWord;
  logic                  lowWrite;
  logic                  memWeHi;
  logic                  memWeLo;

  // Bytes only count while selected; the final CA byte completes caNext.
  assign byteEdge = edge_p & ~csn_s;
  assign caNext   = {ca_q, dq_s};
  assign memAddr  = addr_q[DEPTH_LOG2-1:0];

  // A word is committed only on its low byte, so an aborted high byte never
  // reaches the array. A csn rise in the same clk wins over the data edge.
  assign lowWrite = rstn & hbus_rstn & ~csn_rise & (state_q == WRITE) &
                    byteEdge & ~hiPhase_q & ~isReg_q;
  assign memWeHi  = lowWrite & ~hiMask_q;
  assign memWeLo  = lowWrite & ~rwds_s;

  // Read data source: array for memory space, ID0/CR0 decode for registers.
  always_comb begin
    rdWord = mem[memAddr];
    if (isReg_q) begin
      rdWord = 16'h0000;
      if (addr_q == ID0_ADDR) begin
        rdWord = ID0_VAL;
      end else if (addr_q == CR0_ADDR) begin
        rdWord = cr0_q;
      end
    end
  end

  // Array storage; deliberately not reset so hbus_rstn keeps the contents.
  always_ff @(posedge clk) begin
    if (memWeHi) begin
      mem[memAddr][15:8] <= hiByte_q;
    end
    if (memWeLo) begin
      mem[memAddr][7:0] <= dq_s;
    end
  end

  // Main responder FSM. Either reset returns everything to IDLE; a csn rise
  // closes any transaction and flags a dangling high byte of a write.
  always_ff @(posedge clk) begin
    if (!rstn || !hbus_rstn) begin
      state_q   <= IDLE;
      caCnt_q   <= 3'd0;
      latCnt_q  <= 8'd0;
      ca_q      <= 40'd0;
      addr_q    <= 32'd0;
      isRead_q  <= 1'b0;
      isReg_q   <= 1'b0;
      hiPhase_q <= 1'b1;
      pending_q <= 1'b0;
      hiByte_q  <= 8'h00;
      hiMask_q  <= 1'b0;
      cr0_q     <= CR0_RST;
      dqOut_q   <= 8'h00;
      dqOe_q    <= 1'b0;
      rwdsOut_q <= 1'b0;
      rwdsOe_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (csn_rise) begin
        state_q   <= IDLE;
        dqOut_q   <= 8'h00;
        dqOe_q    <= 1'b0;
        rwdsOut_q <= 1'b0;
        rwdsOe_q  <= 1'b0;
        pending_q <= 1'b0;
        error_q   <= (state_q == WRITE) && pending_q;
      end else begin
        case (state_q)
          IDLE: begin
            if (csn_fall) begin
              state_q   <= CA;
              caCnt_q   <= 3'd0;
              rwdsOe_q  <= 1'b1;
              rwdsOut_q <= 1'b1;
            end
          end
          CA: begin
            if (byteEdge) begin
              ca_q    <= caNext[39:0];
              caCnt_q <= caCnt_q + 3'd1;
              if (caCnt_q == 3'd5) begin
                addr_q    <= caWordAddr(caNext);
                isRead_q  <= caNext[CA_RW];
                isReg_q   <= caNext[CA_AS];
                hiPhase_q <= 1'b1;
                pending_q <= 1'b0;
                // Register writes carry no latency and release RWDS at once
                if (!caNext[CA_RW] && caNext[CA_AS]) begin
                  state_q   <= WRITE;
                  rwdsOe_q  <= 1'b0;
                  rwdsOut_q <= 1'b0;
                end else begin
                  state_q  <= LAT;
                  latCnt_q <= LAT_EDGES;
                end
              end
            end
          end
          LAT: begin
            if (byteEdge) begin
              latCnt_q <= latCnt_q - 8'd1;
              if (latCnt_q == 8'd1) begin
                if (isRead_q) begin
                  state_q <= READ;
                end else begin
                  state_q   <= WRITE;
                  rwdsOe_q  <= 1'b0;
                  rwdsOut_q <= 1'b0;
                end
              end
            end
          end
          WRITE: begin
            if (byteEdge) begin
              if (hiPhase_q) begin
                hiByte_q  <= dq_s;
                hiMask_q  <= rwds_s;
                pending_q <= 1'b1;
                hiPhase_q <= 1'b0;
              end else begin
                pending_q <= 1'b0;
                hiPhase_q <= 1'b1;
                addr_q    <= addr_q + 32'd1;
                // CR0 is the only writable register and ignores the mask
                if (isReg_q && (addr_q == CR0_ADDR)) begin
                  cr0_q <= {hiByte_q, dq_s};
                end
              end
            end
          end
          READ: begin
            if (byteEdge) begin
              dqOe_q <= 1'b1;
              if (hiPhase_q) begin
                dqOut_q   <= rdWord[15:8];
                rwdsOut_q <= 1'b0;
                hiPhase_q <= 1'b0;
              end else begin
                dqOut_q   <= rdWord[7:0];
                rwdsOut_q <= 1'b1;
                hiPhase_q <= 1'b1;
                addr_q    <= addr_q + 32'd1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign hbus_dq_o    = dqOut_q;
  assign hbus_dq_oe   = dqOe_q;
  assign hbus_rwds_o  = rwdsOut_q;
  assign hbus_rwds_oe = rwdsOe_q;
  assign busy         = (state_q != IDLE);
  assign error_o      = error_q;

endmodule
